// File: rtl/modulo_contador_rolhas.sv
// Cork stock counter: consumes one cork per sealing, adds dispenser batches
// saturating at CAP, and requests refills with timeout supervision.
// Optional statistics counter guarded by `ROLHAS_ESTATISTICA_EN.
module modulo_contador_rolhas #(
    parameter int CAP     = 99,
    parameter int LOTE    = 15,
    parameter int LIMIAR  = 5,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vedar,
    input  logic        lote_ok,
    output logic [6:0]  reg_r,
    output logic        vedar_ack,
    output logic        vedar_erro,
    output logic        pedido_repor,
    output logic        excesso,
`ifdef ROLHAS_ESTATISTICA_EN
    output logic [15:0] total_vedacoes,
`endif
    output logic        falha_disp
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [8:0]    CAP_W    = 9'(CAP);
    localparam logic [8:0]    LOTE_W   = 9'(LOTE);
    localparam logic [6:0]    LIMIAR_W = 7'(LIMIAR);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        PEDINDO = 2'd1,
        FALHA   = 2'd2
    } estado_t;

    estado_t       estado_q;
    logic [6:0]    reg_q, reg_d;
    logic [TW-1:0] timer_q;
    logic          ack_q, erro_q, pedido_q, excesso_q, falha_q;
    logic [8:0]    soma_full;
    logic [6:0]    soma;
    logic          excesso_d;

    // Delivery is applied before the sealing request of the same cycle.
    always_comb begin
        soma_full = {2'b00, reg_q} + LOTE_W;
        excesso_d = lote_ok && (soma_full > CAP_W);
        soma      = reg_q;
        if (lote_ok)
            soma = excesso_d ? CAP_W[6:0] : soma_full[6:0];
        reg_d = soma;
        if (vedar && (soma != 7'd0))
            reg_d = soma - 7'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            reg_q     <= '0;
            timer_q   <= '0;
            ack_q     <= 1'b0;
            erro_q    <= 1'b0;
            pedido_q  <= 1'b0;
            excesso_q <= 1'b0;
            falha_q   <= 1'b0;
        end else begin
            reg_q     <= reg_d;
            ack_q     <= vedar && (soma != 7'd0);
            erro_q    <= vedar && (soma == 7'd0);
            excesso_q <= excesso_d;
            case (estado_q)
                OCIOSO: begin
                    if (reg_d <= LIMIAR_W) begin
                        estado_q <= PEDINDO;
                        pedido_q <= 1'b1;
                        timer_q  <= '0;
                    end
                end
                PEDINDO: begin
                    if (lote_ok) begin
                        estado_q <= OCIOSO;
                        pedido_q <= 1'b0;
                    end else if (timer_q == TMO_LAST) begin
                        // Reached exactly TIMEOUT edges after the request rose.
                        estado_q <= FALHA;
                        pedido_q <= 1'b0;
                        falha_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                FALHA: begin
                    if (lote_ok) begin
                        estado_q <= OCIOSO;
                        falha_q  <= 1'b0;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                    pedido_q <= 1'b0;
                    falha_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROLHAS_ESTATISTICA_EN
    logic [15:0] total_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            total_q <= '0;
        else if (vedar && (soma != 7'd0))
            total_q <= total_q + 16'd1;
    end

    assign total_vedacoes = total_q;
`endif

    assign reg_r        = reg_q;
    assign vedar_ack    = ack_q;
    assign vedar_erro   = erro_q;
    assign pedido_repor = pedido_q;
    assign excesso      = excesso_q;
    assign falha_disp   = falha_q;

endmodule

// File: tb/tb_modulo_contador_rolhas.sv
// Directed self-checking bench for modulo_contador_rolhas (TIMEOUT=8).
module tb_modulo_contador_rolhas;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vedar;
    logic        lote_ok;
    logic [6:0]  reg_r;
    logic        vedar_ack, vedar_erro, pedido_repor, excesso, falha_disp;
`ifdef ROLHAS_ESTATISTICA_EN
    logic [15:0] total_vedacoes;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    modulo_contador_rolhas #(
        .CAP(99), .LOTE(15), .LIMIAR(5), .TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vedar        (vedar),
        .lote_ok      (lote_ok),
        .reg_r        (reg_r),
        .vedar_ack    (vedar_ack),
        .vedar_erro   (vedar_erro),
        .pedido_repor (pedido_repor),
        .excesso      (excesso),
`ifdef ROLHAS_ESTATISTICA_EN
        .total_vedacoes (total_vedacoes),
`endif
        .falha_disp   (falha_disp)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // One clock edge with the current inputs, then sample 1 time unit later.
    task automatic step(input logic v, input logic l);
        vedar   = v;
        lote_ok = l;
        @(posedge clk);
        #1;
        vedar   = 1'b0;
        lote_ok = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " reg_r"}, 32'(reg_r), 0);
        check_val({tag, " pedido"}, 32'(pedido_repor), 0);
        check_val({tag, " falha"}, 32'(falha_disp), 0);
        check_val({tag, " ack"}, 32'(vedar_ack), 0);
        check_val({tag, " erro"}, 32'(vedar_erro), 0);
        check_val({tag, " excesso"}, 32'(excesso), 0);
`ifdef ROLHAS_ESTATISTICA_EN
        check_val({tag, " total"}, 32'(total_vedacoes), 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; vedar = 1'b0; lote_ok = 1'b0;
        #1;
        step(0, 0);
        step(0, 0);
        check_reset_outputs("reset");

        // Release: stock 0 already below threshold, request after one edge.
        rst_n = 1'b1;
        step(0, 0);
        check_val("rel pedido", 32'(pedido_repor), 1);
        check_val("rel reg_r", 32'(reg_r), 0);

        step(1, 0);
        check_val("empty erro", 32'(vedar_erro), 1);
        check_val("empty ack", 32'(vedar_ack), 0);
        check_val("empty reg_r", 32'(reg_r), 0);

        step(0, 1);
        check_val("lote reg_r", 32'(reg_r), 15);
        check_val("lote pedido", 32'(pedido_repor), 0);
        check_val("lote excesso", 32'(excesso), 0);

        for (int i = 0; i < 10; i++) begin
            step(1, 0);
            check_val($sformatf("seal%0d ack", i), 32'(vedar_ack), 1);
            check_val($sformatf("seal%0d reg_r", i), 32'(reg_r), 32'(14 - i));
            check_val($sformatf("seal%0d pedido", i), 32'(pedido_repor), (i == 9) ? 32'd1 : 32'd0);
        end

        // Climb 5 -> 95 with six batches, then down to 90.
        for (int i = 0; i < 6; i++) begin
            step(0, 1);
            check_val($sformatf("fill%0d reg_r", i), 32'(reg_r), 32'(20 + 15 * i));
        end
        check_val("fill excesso", 32'(excesso), 0);
        for (int i = 0; i < 5; i++) step(1, 0);
        check_val("at90 reg_r", 32'(reg_r), 90);

        step(0, 1);
        check_val("clip reg_r", 32'(reg_r), 99);
        check_val("clip excesso", 32'(excesso), 1);
        step(0, 0);
        check_val("clip pulse", 32'(excesso), 0);

        for (int i = 0; i < 9; i++) step(1, 0);
        check_val("back90 reg_r", 32'(reg_r), 90);
        step(1, 1);
        check_val("clipseal reg_r", 32'(reg_r), 98);
        check_val("clipseal ack", 32'(vedar_ack), 1);
        check_val("clipseal excesso", 32'(excesso), 1);

        step(0, 1);
        check_val("98+lote reg_r", 32'(reg_r), 99);
        check_val("98+lote excesso", 32'(excesso), 1);
        step(0, 1);
        check_val("cap+lote reg_r", 32'(reg_r), 99);
        check_val("cap+lote excesso", 32'(excesso), 1);
`ifdef ROLHAS_ESTATISTICA_EN
        check_val("total25", 32'(total_vedacoes), 25);
`endif

        // Timeout supervision.
        rst_n = 1'b0;
        step(0, 0);
        check_reset_outputs("reset2");
        rst_n = 1'b1;
        step(0, 0);
        check_val("tmo start pedido", 32'(pedido_repor), 1);
        for (int i = 1; i < 8; i++) begin
            step(0, 0);
            check_val($sformatf("tmo%0d falha", i), 32'(falha_disp), 0);
            check_val($sformatf("tmo%0d pedido", i), 32'(pedido_repor), 1);
        end
        step(0, 0);
        check_val("tmo8 falha", 32'(falha_disp), 1);
        check_val("tmo8 pedido", 32'(pedido_repor), 0);
        step(0, 0);
        check_val("falha held", 32'(falha_disp), 1);
        step(0, 1);
        check_val("recover falha", 32'(falha_disp), 0);
        check_val("recover reg_r", 32'(reg_r), 15);

        // Simultaneous delivery and sealing on empty stock.
        rst_n = 1'b0;
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);
        step(1, 1);
        check_val("both reg_r", 32'(reg_r), 14);
        check_val("both ack", 32'(vedar_ack), 1);
        check_val("both erro", 32'(vedar_erro), 0);
        check_val("both excesso", 32'(excesso), 0);
`ifdef ROLHAS_ESTATISTICA_EN
        check_val("total1", 32'(total_vedacoes), 1);
`endif

        // Reset with stock 40.
        step(0, 1);
        step(0, 1);
        for (int i = 0; i < 4; i++) step(1, 0);
        check_val("at40 reg_r", 32'(reg_r), 40);
        rst_n = 1'b0;
        vedar = 1'b1;
        lote_ok = 1'b1;
        @(posedge clk);
        #1;
        vedar = 1'b0;
        lote_ok = 1'b0;
        check_reset_outputs("reset3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
